// File: rtl/game_pkg.sv
// Shared game-block definitions: screen geometry, player sprite placement defaults
// and the life-cycle state type used by the player sprite controller.
package game_pkg;

  localparam int unsigned RES_H                = 640;
  localparam int unsigned RES_V                = 480;
  localparam int unsigned SPRITE_WIDTH_SCALED  = 32;
  localparam int unsigned SPRITE_HEIGHT_SCALED = 32;

  // Gap kept between the sprite and the screen edges, and height of the strip
  // the player may roam in at the bottom of the screen.
  localparam int unsigned EDGE_MARGIN   = 8;
  localparam int unsigned PLAYER_ZONE_H = 40;

  localparam int unsigned DEF_START_X = (RES_H - SPRITE_WIDTH_SCALED) / 2;
  localparam int unsigned DEF_X_MIN   = EDGE_MARGIN;
  localparam int unsigned DEF_X_MAX   = RES_H - SPRITE_WIDTH_SCALED - EDGE_MARGIN;
  localparam int unsigned DEF_Y_MAX   = RES_V - SPRITE_HEIGHT_SCALED - EDGE_MARGIN;
  localparam int unsigned DEF_Y_MIN   = DEF_Y_MAX - PLAYER_ZONE_H;
  localparam int unsigned DEF_START_Y = DEF_Y_MAX;

  typedef enum logic [1:0] {
    ALIVE,
    DYING,
    RESPAWN
  } life_state_t;

endpackage

// File: rtl/tick_divider.sv
// Free-running clock divider producing a one-cycle tick every DIV cycles.
// Ports:
//   clk  - clock
//   rst  - asynchronous, active-high reset (count restarts at 0)
//   tick - high for one cycle while the count equals DIV-1
module tick_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count_q, count_d;

  assign tick = (count_q == CW'(DIV - 1));

  always_comb begin
    count_d = tick ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sprite_motion.sv
// Player sprite movement controller with alive/dying/respawn life cycle.
// Movement happens in a working register (wx/wy) on divider ticks; the renderer
// only sees the copy taken at the start of blanking (pos_x/pos_y).
// Optional build macro: SPRITE_MOTION_ACCEL_EN - doubles the step after 8
// consecutive ticks held in the same single direction on an axis.
// Ports:
//   clk, rst                       - pixel clock, async active-high reset
//   frame                          - one-cycle pulse at start of blanking
//   btn_left/right/up/down         - debounced direction levels
//   hit                            - one-cycle destroy strobe
//   pos_x, pos_y                   - frame-stable sprite coordinates
//   visible                        - renderer draw enable
//   alive                          - high only while ALIVE
module sprite_motion
  import game_pkg::*;
#(
  parameter int unsigned COORD_W      = 10,
  parameter int unsigned START_X      = DEF_START_X,
  parameter int unsigned START_Y      = DEF_START_Y,
  parameter int unsigned X_MIN        = DEF_X_MIN,
  parameter int unsigned X_MAX        = DEF_X_MAX,
  parameter int unsigned Y_MIN        = DEF_Y_MIN,
  parameter int unsigned Y_MAX        = DEF_Y_MAX,
  parameter int unsigned STEP         = 2,
  parameter int unsigned MOVE_DIV     = 200000,
  parameter int unsigned DEATH_FRAMES = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               hit,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               visible,
  output logic               alive
);

  localparam int unsigned SW = COORD_W + 1;
  // At least 3 bits so the blink bit always exists.
  localparam int unsigned DW = ($clog2(DEATH_FRAMES) > 3) ? $clog2(DEATH_FRAMES) : 3;

  life_state_t        state_q, state_d;
  logic [DW-1:0]      death_q, death_d;
  logic [COORD_W-1:0] wx_q, wx_d, wy_q, wy_d;
  logic [COORD_W-1:0] pos_x_q, pos_y_q;
  logic               visible_q, visible_d, alive_q, alive_d;
  logic               tick;
  logic [SW-1:0]      step_x, step_y;

  tick_divider #(
    .DIV(MOVE_DIV)
  ) u_tick_divider (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // One axis move with saturation. Arithmetic is one bit wider than the
  // coordinate so a decrement below zero shows up in the top bit.
  function automatic logic [COORD_W-1:0] axis_step(
    input logic [COORD_W-1:0] coord,
    input logic               dec,
    input logic               inc,
    input logic [SW-1:0]      step,
    input logic [SW-1:0]      lo,
    input logic [SW-1:0]      hi
  );
    logic [SW-1:0] sum;
    sum = {1'b0, coord};
    if (dec && !inc) begin
      sum = {1'b0, coord} - step;
      if (sum[SW-1] || (sum < lo)) sum = lo;
    end else if (inc && !dec) begin
      sum = {1'b0, coord} + step;
      if (sum > hi) sum = hi;
    end
    return sum[COORD_W-1:0];
  endfunction

`ifdef SPRITE_MOTION_ACCEL_EN
  // Hold counters saturate at 8; direction bit is 1 for right/down.
  logic [3:0] hold_x_q, hold_x_d, hold_y_q, hold_y_d;
  logic [3:0] hold_x_eff, hold_y_eff;
  logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic       single_x, single_y;

  assign single_x   = btn_left ^ btn_right;
  assign single_y   = btn_up ^ btn_down;
  // Any cycle without the same single direction breaks the run.
  assign hold_x_eff = (single_x && (btn_right == dir_x_q)) ? hold_x_q : 4'd0;
  assign hold_y_eff = (single_y && (btn_down == dir_y_q)) ? hold_y_q : 4'd0;
  assign step_x     = (hold_x_eff == 4'd8) ? SW'(2 * STEP) : SW'(STEP);
  assign step_y     = (hold_y_eff == 4'd8) ? SW'(2 * STEP) : SW'(STEP);

  always_comb begin
    hold_x_d = hold_x_eff;
    hold_y_d = hold_y_eff;
    dir_x_d  = single_x ? btn_right : dir_x_q;
    dir_y_d  = single_y ? btn_down : dir_y_q;
    if ((state_q != ALIVE) || hit) begin
      hold_x_d = '0;
      hold_y_d = '0;
    end else if (tick) begin
      if (single_x && (hold_x_eff != 4'd8)) hold_x_d = hold_x_eff + 4'd1;
      if (single_y && (hold_y_eff != 4'd8)) hold_y_d = hold_y_eff + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_x_q <= '0;
      hold_y_q <= '0;
      dir_x_q  <= 1'b0;
      dir_y_q  <= 1'b0;
    end else begin
      hold_x_q <= hold_x_d;
      hold_y_q <= hold_y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
    end
  end
`else
  assign step_x = SW'(STEP);
  assign step_y = SW'(STEP);
`endif

  // Life-cycle state register together with the working position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ALIVE;
      death_q <= '0;
      wx_q    <= COORD_W'(START_X);
      wy_q    <= COORD_W'(START_Y);
    end else begin
      state_q <= state_d;
      death_q <= death_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
    end
  end

  // Next state; hit has priority over a coincident tick so wx/wy hold.
  always_comb begin
    state_d = state_q;
    death_d = death_q;
    wx_d    = wx_q;
    wy_d    = wy_q;
    unique case (state_q)
      ALIVE: begin
        if (hit) begin
          state_d = DYING;
          death_d = '0;
        end else if (tick) begin
          wx_d = axis_step(wx_q, btn_left, btn_right, step_x, SW'(X_MIN), SW'(X_MAX));
          wy_d = axis_step(wy_q, btn_up, btn_down, step_y, SW'(Y_MIN), SW'(Y_MAX));
        end
      end
      DYING: begin
        if (frame) begin
          if (death_q == DW'(DEATH_FRAMES - 1)) begin
            state_d = RESPAWN;
            wx_d    = COORD_W'(START_X);
            wy_d    = COORD_W'(START_Y);
          end else begin
            death_d = death_q + DW'(1);
          end
        end
      end
      RESPAWN: begin
        if (frame) state_d = ALIVE;
      end
      default: state_d = ALIVE;
    endcase
  end

  // Outputs decoded from the next state so they are registered yet valid
  // the cycle after the causing event.
  always_comb begin
    alive_d   = 1'b0;
    visible_d = 1'b0;
    unique case (state_d)
      ALIVE: begin
        alive_d   = 1'b1;
        visible_d = 1'b1;
      end
      DYING:   visible_d = ~death_d[2];
      default: visible_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x_q   <= COORD_W'(START_X);
      pos_y_q   <= COORD_W'(START_Y);
      visible_q <= 1'b1;
      alive_q   <= 1'b1;
    end else begin
      // Latches the pre-tick working position.
      if (frame) begin
        pos_x_q <= wx_q;
        pos_y_q <= wy_q;
      end
      visible_q <= visible_d;
      alive_q   <= alive_d;
    end
  end

  assign pos_x   = pos_x_q;
  assign pos_y   = pos_y_q;
  assign visible = visible_q;
  assign alive   = alive_q;

endmodule

// File: tb/tb_sprite_motion.sv
`timescale 1ns/1ps
module tb_sprite_motion;

  localparam int COORD_W      = 10;
  localparam int START_X      = 304;
  localparam int START_Y      = 440;
  localparam int X_MIN        = 7;   // odd so a partial step to the bound occurs
  localparam int X_MAX        = 600;
  localparam int Y_MIN        = 400;
  localparam int Y_MAX        = 440;
  localparam int STEP         = 2;
  localparam int MOVE_DIV     = 4;
  localparam int DEATH_FRAMES = 60;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame = 1'b0, hit = 1'b0;
  logic bl = 1'b0, br = 1'b0, bu = 1'b0, bd = 1'b0;
  logic [COORD_W-1:0] pos_x, pos_y;
  logic visible, alive;

  sprite_motion #(
    .COORD_W     (COORD_W),
    .START_X     (START_X),
    .START_Y     (START_Y),
    .X_MIN       (X_MIN),
    .X_MAX       (X_MAX),
    .Y_MIN       (Y_MIN),
    .Y_MAX       (Y_MAX),
    .STEP        (STEP),
    .MOVE_DIV    (MOVE_DIV),
    .DEATH_FRAMES(DEATH_FRAMES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .frame    (frame),
    .btn_left (bl),
    .btn_right(br),
    .btn_up   (bu),
    .btn_down (bd),
    .hit      (hit),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .visible  (visible),
    .alive    (alive)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: life is 0 alive, 1 dying, 2 respawn.
  int m_cyc, m_wx, m_wy, m_px, m_py, m_life, m_cnt, m_vis, m_alive;
  int m_run_x, m_run_y, m_dir_x, m_dir_y;

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_wx = START_X; m_wy = START_Y; m_px = START_X; m_py = START_Y;
    m_life = 0; m_cnt = 0; m_vis = 1; m_alive = 1;
    m_run_x = 0; m_run_y = 0; m_dir_x = 0; m_dir_y = 0;
  endtask

  task automatic model_clock();
    bit tk;
    int dx, dy, sx, sy;
    tk = ((m_cyc % MOVE_DIV) == MOVE_DIV - 1);
    m_cyc++;
    if (frame) begin m_px = m_wx; m_py = m_wy; end
    dx = int'(br) - int'(bl);
    dy = int'(bd) - int'(bu);
    sx = STEP; sy = STEP;
`ifdef SPRITE_MOTION_ACCEL_EN
    if (dx == 0 || dx != m_dir_x) m_run_x = 0;
    if (dy == 0 || dy != m_dir_y) m_run_y = 0;
    if (dx != 0) m_dir_x = dx;
    if (dy != 0) m_dir_y = dy;
    if (m_life != 0 || hit) begin m_run_x = 0; m_run_y = 0; end
    if (m_run_x >= 8) sx = 2 * STEP;
    if (m_run_y >= 8) sy = 2 * STEP;
`endif
    case (m_life)
      0: begin
        if (hit) begin
          m_life = 1; m_cnt = 0;
        end else if (tk) begin
          m_wx = clampi(m_wx + dx * sx, X_MIN, X_MAX);
          m_wy = clampi(m_wy + dy * sy, Y_MIN, Y_MAX);
`ifdef SPRITE_MOTION_ACCEL_EN
          if (dx != 0) m_run_x++;
          if (dy != 0) m_run_y++;
`endif
        end
      end
      1: begin
        if (frame) begin
          if (m_cnt == DEATH_FRAMES - 1) begin
            m_life = 2; m_wx = START_X; m_wy = START_Y;
          end else begin
            m_cnt++;
          end
        end
      end
      default: if (frame) m_life = 0;
    endcase
    m_alive = (m_life == 0) ? 1 : 0;
    m_vis = (m_life == 0) ? 1 : (m_life == 1) ? (((m_cnt / 4) % 2) == 0 ? 1 : 0) : 0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    checks++;
    if (int'(pos_x) != m_px || int'(pos_y) != m_py || int'(visible) != m_vis ||
        int'(alive) != m_alive) begin
      failures++;
      $display("FAIL model at %0t: pos=(%0d,%0d) vis=%0d alive=%0d, expected (%0d,%0d) %0d %0d",
               $time, pos_x, pos_y, visible, alive, m_px, m_py, m_vis, m_alive);
    end
  endtask

  // One clock: DUT and model see the same inputs at the posedge.
  task automatic step();
    @(posedge clk);
    if (!rst) model_clock();
    @(negedge clk);
    check_model();
  endtask

  task automatic set_btn(input bit l, input bit r, input bit u, input bit d);
    bl = l; br = r; bu = u; bd = d;
  endtask

  task automatic hold(input int n, input bit l, input bit r, input bit u, input bit d);
    set_btn(l, r, u, d);
    frame = 1'b0; hit = 1'b0;
    repeat (n) step();
  endtask

  task automatic pulse(input bit l, input bit r, input bit u, input bit d);
    set_btn(l, r, u, d);
    frame = 1'b1;
    step();
    frame = 1'b0;
  endtask

  task automatic align();
    set_btn(0, 0, 0, 0);
    for (int i = 0; i < 2 * MOVE_DIV && (m_cyc % MOVE_DIV) != 0; i++) step();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must be valid at once.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_alive", int'(alive), 1);
    check("rst_visible", int'(visible), 1);
    check("rst_pos_x", int'(pos_x), START_X);
    check("rst_pos_y", int'(pos_y), START_Y);
    model_reset();
    frame = 1'b0; hit = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit l, r, u, d;
    int exp_x, exp_y;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // Each record: frame pulse on its first cycle (checked), then 39 more cycles,
    // i.e. 10 move ticks with the record's buttons.
`ifdef SPRITE_MOTION_ACCEL_EN
    tbl[0]  = '{0, 1, 0, 0, 304, 440};
    tbl[1]  = '{0, 1, 0, 0, 328, 440};
    tbl[2]  = '{1, 1, 0, 0, 368, 440};
    tbl[3]  = '{0, 0, 1, 0, 368, 440};
    tbl[4]  = '{0, 0, 1, 0, 368, 416};
    tbl[5]  = '{0, 0, 1, 0, 368, 400};
    tbl[6]  = '{0, 0, 1, 1, 368, 400};
    tbl[7]  = '{0, 0, 0, 1, 368, 400};
    tbl[8]  = '{0, 0, 0, 0, 368, 424};
    tbl[9]  = '{1, 0, 0, 0, 368, 424};
    tbl[10] = '{1, 0, 0, 0, 344, 424};
`else
    tbl[0]  = '{0, 1, 0, 0, 304, 440};
    tbl[1]  = '{0, 1, 0, 0, 324, 440};
    tbl[2]  = '{1, 1, 0, 0, 344, 440};
    tbl[3]  = '{0, 0, 1, 0, 344, 440};
    tbl[4]  = '{0, 0, 1, 0, 344, 420};
    tbl[5]  = '{0, 0, 1, 0, 344, 400};
    tbl[6]  = '{0, 0, 1, 1, 344, 400};
    tbl[7]  = '{0, 0, 0, 1, 344, 400};
    tbl[8]  = '{0, 0, 0, 0, 344, 420};
    tbl[9]  = '{1, 0, 0, 0, 344, 420};
    tbl[10] = '{1, 0, 0, 0, 324, 420};
`endif

    do_reset();

    for (int i = 0; i < 11; i++) begin
      pulse(tbl[i].l, tbl[i].r, tbl[i].u, tbl[i].d);
      check($sformatf("tbl%0d_x", i), int'(pos_x), tbl[i].exp_x);
      check($sformatf("tbl%0d_y", i), int'(pos_y), tbl[i].exp_y);
      check($sformatf("tbl%0d_alive", i), int'(alive), 1);
      hold(39, tbl[i].l, tbl[i].r, tbl[i].u, tbl[i].d);
    end

`ifndef SPRITE_MOTION_ACCEL_EN
    // Walk left to x=100, then let a frame coincide with a right tick.
    align();
    hold(408, 1, 0, 0, 0);
    hold(3, 0, 1, 0, 0);
    pulse(0, 1, 0, 0);
    check("coincide_pre", int'(pos_x), 100);
    align();
    pulse(0, 0, 0, 0);
    check("coincide_post", int'(pos_x), 102);
    // Down to X_MIN+1, then a partial step onto the bound, then stay there.
    hold(188, 1, 0, 0, 0);
    pulse(0, 0, 0, 0);
    check("xmin_plus1", int'(pos_x), X_MIN + 1);
    hold(4, 1, 0, 0, 0);
    pulse(0, 0, 0, 0);
    check("xmin_sat", int'(pos_x), X_MIN);
    hold(40, 1, 0, 0, 0);
    pulse(0, 0, 0, 0);
    check("xmin_hold", int'(pos_x), X_MIN);
`endif

    // Death sequence: hit coincides with a tick while moving right.
    do_reset();
    hold(3, 0, 1, 0, 0);
    hit = 1'b1;
    step();
    hit = 1'b0;
    check("hit_alive", int'(alive), 0);
    check("hit_visible", int'(visible), 1);
    for (int i = 1; i <= DEATH_FRAMES + 1; i++) begin
      if (i == 10) begin
        hit = 1'b1;
        step();
        hit = 1'b0;
        check("hit_in_dying", int'(alive), 0);
      end
      pulse(0, 1, 0, 0);
      if (i < DEATH_FRAMES) begin
        check($sformatf("dying%0d_vis", i), int'(visible), ((i / 4) % 2 == 0) ? 1 : 0);
        check($sformatf("dying%0d_x", i), int'(pos_x), START_X);
      end else if (i == DEATH_FRAMES) begin
        check("respawn_vis", int'(visible), 0);
        check("respawn_alive", int'(alive), 0);
      end else begin
        check("alive_again", int'(alive), 1);
        check("alive_vis", int'(visible), 1);
        check("respawn_pos_x", int'(pos_x), START_X);
        check("respawn_pos_y", int'(pos_y), START_Y);
      end
      hold(3, 0, 1, 0, 0);
    end

    // Reset while dying.
    do_reset();
    hold(20, 0, 1, 0, 0);
    pulse(0, 0, 0, 0);
    check("pre_die_x", int'(pos_x), START_X + 10);
    hit = 1'b1;
    step();
    hit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pulse(0, 0, 0, 0);
      hold(2, 0, 0, 0, 0);
    end
    check("dying5_vis", int'(visible), 0);
    check("dying5_alive", int'(alive), 0);
    do_reset();

`ifdef SPRITE_MOTION_ACCEL_EN
    // Eight ticks at STEP, the ninth at 2*STEP; a release restarts at STEP.
    hold(32, 0, 1, 0, 0);
    hold(4, 0, 1, 0, 0);
    pulse(0, 1, 0, 0);
    check("accel_ninth", int'(pos_x), START_X + 8 * STEP + 2 * STEP);
    hold(3, 0, 1, 0, 0);
    hold(4, 0, 0, 0, 0);
    hold(4, 0, 1, 0, 0);
    pulse(0, 0, 0, 0);
    check("accel_restart", int'(pos_x), START_X + 8 * STEP + 4 * STEP + STEP);
`endif

    // Randomized run against the model.
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        logic [3:0] b;
        b = 4'($urandom_range(0, 15));
        set_btn(b[0], b[1], b[2], b[3]);
      end
      frame = ($urandom_range(0, 9) == 0);
      hit = ($urandom_range(0, 399) == 0);
      step();
    end
    frame = 1'b0;
    hit = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_motion.md
# sprite_motion

Parametrised 2-axis movement controller for a player-type sprite, with a life/respawn state machine. It runs on the pixel clock inside the game block. It takes debounced direction buttons and a hit strobe from collision logic, and publishes frame-stable coordinates plus visibility to the sprite renderer. Motion rate comes from an internal tick divider. Position updates are confined to a working register and are exposed only at the start of blanking.

## Interface
- COORD_W, 10, width of each coordinate
- START_X, 304, respawn/reset X (sprite left edge)
- START_Y, 440, respawn/reset Y (sprite top edge)
- X_MIN, 8, smallest legal X
- X_MAX, 600, largest legal X
- Y_MIN, 400, smallest legal Y
- Y_MAX, 440, largest legal Y
- STEP, 2, pixels per move tick (1..63)
- MOVE_DIV, 200000, clk cycles per move tick (>=2)
- DEATH_FRAMES, 60, frames spent in DYING (>=1)
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- frame  in  1  one-cycle pulse at start of blanking interval
- btn_left, btn_right, btn_up, btn_down  in  1 each  debounced, level
- hit  in  1  one-cycle strobe: sprite destroyed
- pos_x  out  COORD_W  frame-stable X
- pos_y  out  COORD_W  frame-stable Y
- visible  out  1  renderer draw enable
- alive  out  1  high only in ALIVE

## Operation
- Reset: wx=pos_x=START_X, wy=pos_y=START_Y, divider=0, state=ALIVE, visible=1, alive=1, death count=0.
- Divider: counts 0..MOVE_DIV-1 and wraps. A tick pulses for one cycle when the count equals MOVE_DIV-1. The divider free-runs in all states.
- Per axis on tick, ALIVE only:
  - Exactly one of the pair pressed: move by STEP in that direction.
  - Both or neither pressed: no move.
  - Arithmetic is done in COORD_W+1 bits.
  - Result is saturated to [MIN, MAX]. A partial step to the bound is taken, never skipped.
- Up decreases Y. Down increases Y.
- States:
  - ALIVE: on hit, go to DYING and clear the death count.
  - DYING:
    - Movement is frozen.
    - The death count increments on each frame.
    - visible = ~count[2] (blinks every 4 frames).
    - When the count reaches DEATH_FRAMES-1 on a frame, go to RESPAWN.
  - RESPAWN:
    - wx/wy are loaded with START on entry.
    - visible=0.
    - On the next frame, go to ALIVE with visible=1.
- hit is ignored outside ALIVE.
- Reset mid-DYING returns immediately to ALIVE at START.

## Timing
- On frame: pos_x/pos_y <= wx/wy.
- Frame and tick in the same cycle: pos latches the pre-tick value, and the tick is still applied to wx/wy.
- hit and tick in the same cycle: hit wins, and wx/wy hold.
- Button to pos latency: wait for the next tick, then the next frame.
- alive and visible are registered and update in the cycle after the causing event. At reset they are already valid.
- Outputs change only on a frame cycle. Exception: alive and visible in DYING/RESPAWN, which also change only on frame cycles or on the cycle after hit.

## Configuration
- SPRITE_MOTION_ACCEL_EN defined:
  - Per-axis hold counter of ticks with the same single direction.
  - After 8 consecutive such ticks, the step becomes 2*STEP.
  - The counter resets on direction change, release, both pressed, hit or rst.
  - Saturation rules are unchanged.
- Not defined: the step is always STEP and there is no hold counter.

## Structure
- Shared game_pkg holds:
  - RES_H, RES_V, SPRITE_WIDTH_SCALED, SPRITE_HEIGHT_SCALED
  - Default START/MIN/MAX values derived from them
  - typedef life_state_t {ALIVE, DYING, RESPAWN}
- Sub-module tick_divider (parameter DIV): counter plus tick pulse. It is reusable by the alien formation logic.
- An axis update with clamp is a function, instantiated twice.

## Test plan
- Reset, MOVE_DIV=4, hold btn_right, frame every 40 cycles -> pos_x goes 304, then 324 after the first frame following 10 ticks; pos_y stays 440.
- wx=X_MIN+1, STEP=2, btn_left, one tick -> wx=8 (saturated); further ticks -> stays 8.
- btn_left+btn_right both held across 5 ticks -> wx unchanged. btn_up at Y_MIN=400 -> wy stays 400.
- hit while moving -> alive=0 next cycle; visible toggles every 4 frames; after 60 frames state goes to RESPAWN; next frame pos=(304,440), visible=1, alive=1. A hit during DYING is ignored.
- frame and tick coincide with btn_right at wx=100 -> pos_x=100 that frame, then 102 on the following frame. rst asserted mid-DYING -> immediately alive=1, pos=(304,440).
- With SPRITE_MOTION_ACCEL_EN and btn_right held from 100 -> increments are 2,2,…(8 ticks), then 4. Release and re-press -> back to 2.
